// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner. Latches the whole pattern
// once per frame so the display never tears, then lights one digit per slot.
module seg_scan_driver #(
    parameter int NDIG           = 6,
    parameter int DWELL          = 4,
    parameter int BLANK          = 1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [8*NDIG-1:0]   seg_in,
    output logic [NDIG-1:0]     an,
    output logic [7:0]          seg,
    output logic [2:0]          digit_idx,
    output logic                frame_start
);

    localparam int              CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DWELL - 1);
    localparam logic [2:0]      IDX_FIRST = 3'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_OFF    = {NDIG{AN_ACTIVE_LOW}};
    localparam logic [7:0]      SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [8*NDIG-1:0] frame_q, frame_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [2:0]        digit_idx_q, digit_idx_d;
    logic              frame_start_q, frame_start_d;

    logic              capture;
    logic [8*NDIG-1:0] src;
    logic [7:0]        sel_byte;
    logic [NDIG-1:0]   sel_an;

    always_comb begin
        capture  = en && (cnt_q == '0) && (idx_q == IDX_FIRST);
        // On the capture edge the fresh input feeds the outputs directly so
        // BLANK=0 shows the new frame without a stale cycle.
        src      = capture ? seg_in : frame_q;
        sel_byte = '0;
        sel_an   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (int'(idx_q) == i) begin
                sel_byte  = src[8*i +: 8];
                sel_an[i] = 1'b1;
            end
        end

        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        an_d          = an_q;
        seg_d         = seg_q;
        digit_idx_d   = digit_idx_q;
        frame_start_d = 1'b0;

        if (!en) begin
            cnt_d = '0;
            idx_d = IDX_FIRST;
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == '0) ? IDX_FIRST : idx_q - 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            frame_d       = src;
            frame_start_d = capture;
            digit_idx_d   = idx_q;
            if (int'(cnt_q) < BLANK) begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end else begin
                an_d  = sel_an ^ AN_OFF;
                seg_d = sel_byte ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= IDX_FIRST;
            frame_q       <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            digit_idx_q   <= IDX_FIRST;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            digit_idx_q   <= digit_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three configurations driven side by side, with a
// position-in-frame reference model feeding a scoreboard queue.
module tb_seg_scan_driver;

    typedef struct {
        int         dut;
        logic [5:0] an;
        logic [7:0] seg;
        logic [2:0] didx;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en     [3];
    logic [47:0] seg_in [3];
    logic [5:0]  an_o   [3];
    logic [7:0]  seg_o  [3];
    logic [2:0]  didx_o [3];
    logic        fs_o   [3];

    // dut 0: defaults, dut 1: DWELL=2 BLANK=0, dut 2: active-high polarity
    int cfg_dwell [3] = '{4, 2, 4};
    int cfg_blank [3] = '{1, 0, 1};
    bit cfg_anl   [3] = '{1'b1, 1'b1, 1'b0};
    bit cfg_segl  [3] = '{1'b1, 1'b1, 1'b0};

    int          m_k     [3];
    logic [47:0] m_frame [3];
    logic [2:0]  m_didx  [3];
    exp_t        sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg_scan_driver u_dut_a (
        .clk(clk), .rst(rst), .en(en[0]), .seg_in(seg_in[0]),
        .an(an_o[0]), .seg(seg_o[0]), .digit_idx(didx_o[0]), .frame_start(fs_o[0])
    );

    seg_scan_driver #(.DWELL(2), .BLANK(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en[1]), .seg_in(seg_in[1]),
        .an(an_o[1]), .seg(seg_o[1]), .digit_idx(didx_o[1]), .frame_start(fs_o[1])
    );

    seg_scan_driver #(.AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .en(en[2]), .seg_in(seg_in[2]),
        .an(an_o[2]), .seg(seg_o[2]), .digit_idx(didx_o[2]), .frame_start(fs_o[2])
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for the coming edge, from the edge's position in the frame.
    task automatic predict(input int d);
        exp_t       e;
        logic [5:0] an_off;
        logic [7:0] seg_off;
        logic [5:0] one;
        int         per, p, slot, off, dig;
        an_off  = {6{cfg_anl[d]}};
        seg_off = {8{cfg_segl[d]}};
        e.dut   = d;
        e.an    = an_off;
        e.seg   = seg_off;
        e.fs    = 1'b0;
        if (rst) begin
            m_k[d]     = 0;
            m_frame[d] = '0;
            m_didx[d]  = 3'd5;
        end else if (!en[d]) begin
            m_k[d] = 0;
        end else begin
            per  = 6 * cfg_dwell[d];
            p    = m_k[d] % per;
            slot = p / cfg_dwell[d];
            off  = p % cfg_dwell[d];
            dig  = 5 - slot;
            if (p == 0) m_frame[d] = seg_in[d];
            e.fs      = (p == 0);
            m_didx[d] = 3'(dig);
            if (off >= cfg_blank[d]) begin
                one   = 6'b000001;
                e.an  = an_off ^ (one << dig);
                e.seg = m_frame[d][8*dig +: 8] ^ seg_off;
            end
            m_k[d]++;
        end
        e.didx = m_didx[d];
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        for (int d = 0; d < 3; d++) predict(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 48'd0, 48'd1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("an%0d", e.dut),   48'(an_o[e.dut]),   48'(e.an));
                chk($sformatf("seg%0d", e.dut),  48'(seg_o[e.dut]),  48'(e.seg));
                chk($sformatf("didx%0d", e.dut), 48'(didx_o[e.dut]), 48'(e.didx));
                chk($sformatf("fs%0d", e.dut),   48'(fs_o[e.dut]),   48'(e.fs));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d]     = 1'b1;
            seg_in[d] = {$urandom, $urandom};
        end
        @(negedge clk);
        repeat (3) step();

        seg_in[0] = 48'h06_05_04_03_02_01;
        seg_in[1] = 48'h06_05_04_03_02_01;
        seg_in[2] = 48'h3F_11_22_44_08_80;
        rst = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 10) seg_in[0] = {6{8'hFF}};
            if (e == 30) seg_in[1] = 48'hA1_B2_C3_D4_E5_F6;
            step();
        end

        // Mid-frame reset, then an enable gap on dut 0 starting at edge 7.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        seg_in[0] = 48'h10_20_40_01_02_04;
        for (int e = 1; e <= 40; e++) begin
            en[0] = !(e >= 7 && e <= 11);
            if (e % 5 == 0) begin
                seg_in[1] = {$urandom, $urandom};
                seg_in[2] = {$urandom, $urandom};
            end
            step();
        end

        // Randomised enables and data to stress slot boundaries and frame latching.
        for (int e = 0; e < 80; e++) begin
            for (int d = 0; d < 3; d++) begin
                en[d] = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 3) == 0) seg_in[d] = {$urandom, $urandom};
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the 48-bit, six-digit segment-pattern vector produced by the clock/setting block and drives a time-multiplexed common-anode 7-segment display.
- Latches the whole pattern once per frame so the display never tears, then scans one digit at a time.
- Inserts a blanking interval between digits to suppress ghosting.
- Sits between the clock's display output and the board's anode and segment pins.

Parameters:
- NDIG, 6, number of digits scanned; seg_in width is 8*NDIG.
- DWELL, 4, clk cycles per digit slot; legal range is 1 or more.
- BLANK, 1, leading cycles of each slot with all anodes off; legal range is 0 to DWELL-1.
- AN_ACTIVE_LOW, 1, 1 means an asserted digit drives its an bit to 0.
- SEG_ACTIVE_LOW, 1, 1 means a lit segment drives its seg bit to 0.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 blanks the display and parks the scanner.
- seg_in  input  8*NDIG  segment patterns; byte i is seg_in[8i+7:8i], bit value 1 means the segment is lit; byte NDIG-1 is the leftmost digit (hour tens).
- an  output  NDIG  anode selects; an[i] enables digit i.
- seg  output  8  segment lines for the currently enabled digit; byte bit order is passed through unchanged.
- digit_idx  output  3  index of the current slot's digit.
- frame_start  output  1  one-cycle pulse, registered, marking a frame capture.

Behaviour:
- Reset values (rst sampled high at an edge): an = all inactive, seg = all inactive, digit_idx = NDIG-1, frame_start = 0, internal frame register = 0, cnt = 0, idx = NDIG-1. rst takes priority over en.
- Counters:
  - cnt runs 0..DWELL-1 and increments every enabled edge.
  - When cnt wraps to 0, idx decrements. idx wraps from 0 back to NDIG-1.
  - Scan order is NDIG-1, NDIG-2, ..., 0, then repeats.
- Capture edge: any enabled edge with cnt==0 and idx==NDIG-1.
  - frame <= seg_in.
  - frame_start <= 1 on that edge and 0 on all other edges.
- Output update: all outputs are registered and computed from pre-edge cnt/idx.
  - If cnt < BLANK: an and seg are set all inactive (blank).
  - Otherwise: an asserts only bit idx, and seg = byte idx of the data source.
  - The data source is seg_in at a capture edge and frame at every other edge. This makes BLANK=0 display the fresh frame with no stale cycle.
  - digit_idx <= idx on every enabled edge.
- Timing:
  - Frame period is NDIG*DWELL cycles.
  - Each digit is lit for DWELL-BLANK cycles per frame.
  - Output latency is 1 cycle from counter state.
- Tear-free rule: seg_in changes between capture edges never reach seg until the next capture edge.
- en=0 at an edge:
  - an and seg go all inactive; frame_start = 0.
  - cnt resets to 0 and idx to NDIG-1; frame is held.
  - The first edge with en=1 is a capture edge, so the scan restarts at the leftmost digit.
- Mid-frame rst: identical to en=0, except frame also clears to 0. The first edge after release is a capture edge.
- Polarity:
  - Inactive an bit = AN_ACTIVE_LOW; active bit = ~AN_ACTIVE_LOW.
  - seg = byte XOR {8{SEG_ACTIVE_LOW}}.
  - Blank seg = {8{SEG_ACTIVE_LOW}}.
- At most one an bit is ever active. No two-digit overlap is allowed on any cycle, including slot boundaries.

Test Plan:
- Reset: hold rst=1 for 3 edges with en=1 and seg_in random -> an=6'b111111, seg=8'hFF, frame_start=0, digit_idx=5 on every cycle.
- Scan order (defaults): seg_in = bytes 5..0 set to 06,05,04,03,02,01 hex; release rst -> at edge e1, frame_start=1 and the display is blank. Edges e2–e4: an=6'b011111, seg=8'hF9. Edge e5: blank. Edges e6–e8: an=6'b101111, seg=8'hFA. Continue through digit 0 (seg=8'hFE). frame_start recurs at e25, e49, and every 24 cycles thereafter.
- Tear-free: change seg_in to all 8'hFF at edge e10 -> seg keeps the old pattern through e24. From e26 every lit slot shows seg=8'h00.
- BLANK=0, DWELL=2: -> no all-off cycle occurs. an changes every 2 edges. Digit 5 is lit with the fresh seg_in on the capture edge itself. Frame period is 12 cycles.
- en toggle: drop en at e7 for 5 edges -> all off and frame_start=0 for that window. On the first en=1 edge, frame_start=1 and digit 5 restarts.
- Polarity: AN_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0 -> reset gives an=0 and seg=0. A lit slot for digit 5 with byte 8'h3F gives an=6'b100000 and seg=8'h3F.
